// File: rtl/uart_rx_pkg.sv
// Shared UART framing constants and bit-timing helpers for the TX and RX sides.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package uart_rx_pkg;

    // Default line rate and clock frequency shared with uart_tx.
    localparam int BAUD_DEF   = 115200;
    localparam int F_DEF      = 50000000;

    // 8N1 framing: start + 8 data + 1 stop.
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    // Clocks per bit; callers must keep this >= 4.
    function automatic int cpb_of(input int f, input int baud);
        return f / baud;
    endfunction

    // Offset from the detected start edge to the start-bit centre.
    function automatic int half_of(input int f, input int baud);
        return (f / baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial line in, byte/strobe/status out.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must take each valid pulse as it comes.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    // The receiver drives the outputs and samples rx.
    modport master (input rx, output data, output valid, output frame_err, output busy);
    // The line driver / byte consumer side.
    modport slave  (output rx, input data, input valid, input frame_err, input busy);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs (serial lines, buttons).
// Latency: 2 clk.
// Backpressure: none.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Resets to all ones so an idle-high line is not seen as a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: serial rx -> byte with one-cycle valid, framing-error strobe.
// Latency: ~2 + HALF + 9*CPB + 1 clk from falling start edge to valid.
// Backpressure: none; each byte is presented once and held on data until the next good byte.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = BAUD_DEF,
    parameter int F    = F_DEF
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);
    localparam int CPB  = cpb_of(F, BAUD);
    localparam int HALF = half_of(F, BAUD);
    localparam int CW   = $clog2(CPB);
    localparam int IW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CPB_M1   = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_s;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [DATA_BITS-1:0]   sh_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   busy;
    logic                   tick;

    sync_2ff #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.rx),
        .q_o (rx_s)
    );

    assign tick = (cnt_q == '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: every decision is taken on the synchronised line at a tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (!rx_s) state_d = S_START;
            S_START:     if (tick)  state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (tick && idx_q == IDX_LAST) state_d = S_STOP;
            S_STOP:      if (tick)  state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rx_s)  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs: busy covers everything from start detection until back in IDLE.
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Bit timer, shifter and output strobes; strobes default low so they last one clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s) cnt_q <= HALF_M1;
                end
                S_START: begin
                    if (tick) begin
                        cnt_q <= CPB_M1;
                        idx_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        sh_q  <= {rx_s, sh_q[DATA_BITS-1:1]};
                        cnt_q <= CPB_M1;
                        idx_q <= idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            data_q  <= sh_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a queue scoreboard and an independent output monitor.
// Runs at a reduced clock/baud ratio (CPB=16, HALF=8) to keep frames short.
// Stimulus drives rx on the falling edge; the monitor samples on the falling edge.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int F     = 50000000;
    localparam int BAUD  = 3125000;
    localparam int CPB   = 16;
    localparam int HALF  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if u_if ();

    uart_rx #(.BAUD(BAUD), .F(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    typedef struct packed {
        logic       ferr;
        logic [7:0] dat;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         checks    = 0;
    int         errors    = 0;
    int         n_valid   = 0;
    int         n_ferr    = 0;
    int         exp_valid = 0;
    int         exp_ferr  = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_good(input logic [7:0] b);
        sb_q.push_back('{ferr: 1'b0, dat: b});
        last_good = b;
        exp_valid++;
    endtask

    task automatic push_ferr();
        sb_q.push_back('{ferr: 1'b1, dat: last_good});
        exp_ferr++;
    endtask

    // One 8N1 frame, LSB first; leaves rx at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        u_if.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            u_if.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        u_if.rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  u_if.data,      32'h00);
        check({tag, "_valid"}, u_if.valid,     32'h0);
        check({tag, "_ferr"},  u_if.frame_err, 32'h0);
        check({tag, "_busy"},  u_if.busy,      32'h0);
    endtask

    // Monitor: every output strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && (u_if.valid || u_if.frame_err)) begin
            if (u_if.valid) n_valid++;
            if (u_if.frame_err) n_ferr++;
            if (u_if.valid && u_if.frame_err) begin
                checks++;
                errors++;
                $display("FAIL strobe_exclusive valid=1 frame_err=1 required one-hot");
            end
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe valid=%0b frame_err=%0b data=%02h required=no output",
                         u_if.valid, u_if.frame_err, u_if.data);
            end else begin
                mon_e = sb_q.pop_front();
                check("strobe_kind", {31'd0, u_if.frame_err}, {31'd0, mon_e.ferr});
                check("strobe_data", {24'd0, u_if.data}, {24'd0, mon_e.dat});
            end
        end
    end

    initial begin
        int nv0;
        int nf0;
        int busy_cnt;

        u_if.rx = 1'b1;
        rst     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Single byte from an idle line.
        nv0 = n_valid;
        push_good(8'hA5);
        send_byte(8'hA5, 1'b1);
        check("a5_busy_after_stop", {31'd0, u_if.busy}, 32'd0);
        check("a5_valid_count", n_valid - nv0, 32'd1);
        check("a5_data_held", {24'd0, u_if.data}, 32'hA5);
        repeat (2 * CPB) @(negedge clk);

        // Back-to-back frames without idle gap.
        nv0 = n_valid;
        for (int b = 0; b < 8; b++) begin
            push_good(8'(b));
            send_byte(8'(b), 1'b1);
        end
        repeat (2 * CPB) @(negedge clk);
        check("b2b_valid_count", n_valid - nv0, 32'd8);

        // Short low glitch on an idle line.
        busy_cnt = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            if (i == 0) u_if.rx = 1'b0;
            if (i == 4) u_if.rx = 1'b1;
            @(negedge clk);
            if (u_if.busy) busy_cnt++;
        end
        check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
        check("glitch_busy_short", {31'd0, busy_cnt < HALF + 3}, 32'd1);
        check("glitch_idle_after", {31'd0, u_if.busy}, 32'd0);

        // Framing error followed by a held-low line, then a good byte.
        nf0 = n_ferr;
        nv0 = n_valid;
        push_ferr();
        send_byte(8'h3C, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("ferr_busy_while_low", {31'd0, u_if.busy}, 32'd1);
        u_if.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("ferr_count", n_ferr - nf0, 32'd1);
        check("ferr_no_valid", n_valid - nv0, 32'd0);
        check("ferr_data_kept", {24'd0, u_if.data}, 32'h07);
        push_good(8'h55);
        send_byte(8'h55, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("after_ferr_data", {24'd0, u_if.data}, 32'h55);

        // Reset in the middle of bit 4 of a frame.
        u_if.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            u_if.rx = (i < 2) ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        u_if.rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        u_if.rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        last_good = 8'h00;
        repeat (10 * CPB) @(negedge clk);
        nv0 = n_valid;
        push_good(8'hC3);
        send_byte(8'hC3, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("midreset_valid_count", n_valid - nv0, 32'd1);

        // Serializer-driven stream with a one-bit idle gap between frames.
        nv0 = n_valid;
        for (int b = 0; b < 8; b++) begin
            push_good(8'(b));
            send_byte(8'(b), 1'b1);
            repeat (CPB) @(negedge clk);
        end

        // Bounded drain of any outstanding expectations.
        for (int i = 0; i < FRAME_BITS * CPB && sb_q.size() != 0; i++) @(negedge clk);
        repeat (CPB) @(negedge clk);
        check("loop_valid_count", n_valid - nv0, 32'd8);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        check("total_valid", n_valid, exp_valid);
        check("total_ferr", n_ferr, exp_ferr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver: the receive-side counterpart of uart_tx.
- Converts the asynchronous serial line rx into parallel bytes, LSB first.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between an external pin or a uart_tx loopback and on-chip consumers such as LEDs or counters; shares BAUD/F parameterisation with uart_tx.

Parameters:
BAUD, 115200, line bit rate in bits/s
F, 50000000, clk frequency in Hz
(derived localparams) CPB = F/BAUD (434 at defaults), clocks per bit; HALF = CPB/2 (217), start-bit mid-point offset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
rx  input  1  serial line, idles high, asynchronous to clk
data  output  8  last correctly received byte, held until the next good byte
valid  output  1  one-clk pulse when data has just been updated
frame_err  output  1  one-clk pulse when the stop bit is sampled low
busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, data=8'h00, valid=0, frame_err=0, busy=0, counters=0, synchroniser flops=1 (line-idle value).
- rx passes through a 2-FF synchroniser; rx_s denotes its output. All decisions use rx_s only.
- Bit-timing counter cnt counts down to 0; "tick" means cnt==0.
- Bit index idx is 0..7. Shift register sh is 8 bits, filled LSB first (shift right, new bit enters at bit 7).
- IDLE: busy=0. When rx_s==0, load cnt=HALF-1 and go to START. busy goes high the next cycle.
- START: on tick, sample rx_s.
  - rx_s==0: load cnt=CPB-1, idx=0, go to DATA.
  - rx_s==1: glitch; return to IDLE with no output pulse.
- DATA: on tick, shift rx_s into sh and reload cnt=CPB-1.
  - idx==7: go to STOP.
  - otherwise: idx+1.
- STOP: on tick, sample rx_s.
  - rx_s==1: data<=sh, valid=1 for exactly one cycle, go to IDLE.
  - rx_s==0: frame_err=1 for exactly one cycle, data unchanged, no valid, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A line held low (break) never produces spurious bytes.
- Sampling points land at bit centres: start sample at HALF clocks after the detected edge; each later sample CPB clocks after the previous one.
- Latency: valid asserts 1 clk after the stop-bit sample, i.e. about 2 (sync) + HALF + 9*CPB + 1 clks after the falling start edge.
- Back-to-back frames: returning to IDLE at the stop-bit centre leaves half a bit of margin. A start edge immediately following the stop bit must be caught.
- valid and frame_err are never high in the same cycle; each pulse is exactly one cycle wide.
- Reset mid-frame: everything aborts to the reset values immediately. After release, the receiver must not lock onto the middle of a frame in progress unless rx_s is low. Mis-framing after a mid-frame release is tolerated; correct operation resumes after a line-idle period of at least 10 bit times.
- Width rules: cnt is $clog2(CPB) bits wide. Default parameters must give CPB >= 4; behaviour for smaller ratios is undefined.

Decomposition:
- Shared include alongside uart_tx (uart_defs.vh): default BAUD/F values, the CPB/HALF derivation, and the frame length constant (8 data bits, 1 stop bit) so TX and RX cannot diverge.
- State encodings (IDLE, START, DATA, STOP, WAIT_HIGH) are local to uart_rx.
- One sub-module: sync_2ff (two-flop synchroniser, reset value 1, parameterised width). It is reusable for other asynchronous inputs such as buttons.

Test Plan:
- Drive byte 8'hA5 at 115200 from an idle-high line -> exactly one valid pulse with data=8'hA5; frame_err never set; busy falls after the stop-bit sample.
- Back-to-back frames 8'h00 through 8'h07 with no idle gap -> 8 valid pulses, data values 0..7 in order.
- Low glitch of 100 clks (less than HALF=217) on an idle line -> no valid, no frame_err, state back in IDLE, busy high for less than 220 clks.
- Frame 8'h3C with stop bit driven 0, then line held low for 2 bit times before going high -> one frame_err pulse, no valid, data retains its previous value. A following good byte 8'h55 is received correctly.
- Assert rst during bit 4 of a frame, release, idle 10 bit times, send 8'hC3 -> all outputs at reset values during reset; afterwards a single valid with data=8'hC3.
- Loopback with uart_tx (same BAUD/F) sending 0..7 -> uart_rx reproduces the sequence 0..7 with valid count equal to the bytes sent.
